// File: rtl/bsg_cgol_job_arbiter.sv
// Round-robin job arbiter: locks one bsg_cgol engine to a ring requester for a
// full job (input burst, then result burst) before re-arbitrating.
module bsg_cgol_job_arbiter #(
    parameter int data_width_p = 64,
    parameter int words_in_p   = 101,
    parameter int words_out_p  = 100
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         en_i,
    input  logic [1:0]                   v_i,
    input  logic [1:0][data_width_p-1:0] data_i,
    output logic [1:0]                   ready_o,
    output logic [1:0]                   v_o,
    output logic [data_width_p-1:0]      data_o,
    input  logic [1:0]                   yumi_i,
    output logic                         eng_v_o,
    output logic [data_width_p-1:0]      eng_data_o,
    input  logic                         eng_ready_i,
    input  logic                         eng_v_i,
    input  logic [data_width_p-1:0]      eng_data_i,
    output logic                         eng_yumi_o,
    output logic                         busy_o,
    output logic                         owner_o
);
    localparam int max_words_lp = (words_in_p > words_out_p) ? words_in_p : words_out_p;
    localparam int cnt_width_lp = $clog2(max_words_lp + 1);
    localparam logic [cnt_width_lp-1:0] in_last_lp  = cnt_width_lp'(words_in_p - 1);
    localparam logic [cnt_width_lp-1:0] out_last_lp = cnt_width_lp'(words_out_p - 1);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp  = cnt_width_lp'(1);

    typedef enum logic [1:0] {e_idle = 2'd0, e_load = 2'd1, e_unload = 2'd2} state_e;

    state_e                  state;
    logic                    owner;
    logic                    last_grant;
    logic [cnt_width_lp-1:0] cnt;

    logic in_load, in_unload, in_xfer, grant_v, grantee;
    logic [1:0] owner_onehot;

    assign in_load      = (state == e_load);
    assign in_unload    = (state == e_unload);
    assign owner_onehot = owner ? 2'b10 : 2'b01;

    // Contention alternates away from the last finished job's owner.
    assign grant_v = en_i & (|v_i);
    assign grantee = (&v_i) ? ~last_grant : v_i[1];

    // Datapath is pure muxing: no added latency, no ready->valid or yumi->valid paths.
    assign eng_v_o    = in_load & v_i[owner];
    assign eng_data_o = eng_v_o ? data_i[owner] : '0;
    assign ready_o    = (in_load & eng_ready_i) ? owner_onehot : 2'b00;
    assign in_xfer    = eng_v_o & eng_ready_i;

    // Engine results are only consumed in UNLOAD, so an early result simply waits.
    assign v_o        = (in_unload & eng_v_i) ? owner_onehot : 2'b00;
    assign data_o     = (|v_o) ? eng_data_i : '0;
    assign eng_yumi_o = in_unload & eng_v_i & yumi_i[owner];

    assign busy_o  = in_load | in_unload;
    assign owner_o = owner;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= e_idle;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            case (state)
                e_idle: begin
                    if (grant_v) begin
                        owner <= grantee;
                        cnt   <= '0;
                        state <= e_load;
                    end
                end
                e_load: begin
                    if (in_xfer) begin
                        if (cnt == in_last_lp) begin
                            cnt   <= '0;
                            state <= e_unload;
                        end else begin
                            cnt <= cnt + cnt_one_lp;
                        end
                    end
                end
                e_unload: begin
                    if (eng_yumi_o) begin
                        if (cnt == out_last_lp) begin
                            cnt        <= '0;
                            last_grant <= owner;
                            state      <= e_idle;
                        end else begin
                            cnt <= cnt + cnt_one_lp;
                        end
                    end
                end
                default: state <= e_idle;
            endcase
        end
    end
endmodule

// File: tb/tb_bsg_cgol_job_arbiter.sv
// Directed bench for bsg_cgol_job_arbiter: job-level reference model compared
// every cycle, plus literal checks on timing, grant order and word logs.
module tb_bsg_cgol_job_arbiter;
    localparam int DW = 16;
    localparam int WI = 3;
    localparam int WO = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en_i = 1'b1;
    logic [1:0]          v_i = '0;
    logic [1:0][DW-1:0]  data_i = '0;
    logic [1:0]          ready_o;
    logic [1:0]          v_o;
    logic [DW-1:0]       data_o;
    logic [1:0]          yumi_i = '0;
    logic                eng_v_o;
    logic [DW-1:0]       eng_data_o;
    logic                eng_ready_i = 1'b1;
    logic                eng_v_i = 1'b0;
    logic [DW-1:0]       eng_data_i = '0;
    logic                eng_yumi_o;
    logic                busy_o;
    logic                owner_o;

    bsg_cgol_job_arbiter #(.data_width_p(DW), .words_in_p(WI), .words_out_p(WO)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
        .eng_v_o(eng_v_o), .eng_data_o(eng_data_o), .eng_ready_i(eng_ready_i),
        .eng_v_i(eng_v_i), .eng_data_i(eng_data_i), .eng_yumi_o(eng_yumi_o),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] in_log[$];
    logic [DW-1:0] res_log[$];
    int            grant_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Job-level model: a job is "active", has loaded some words and returned some.
    bit         m_active = 0, m_owner = 0, m_last = 1, prev_busy = 0;
    int         m_loaded = 0, m_ret = 0;
    logic       loading, unloading, e_eng_v, e_yumi;
    logic [1:0] own_bit, e_ready, e_v_o;
    logic [DW-1:0] e_eng_data, e_data_o;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 0; m_owner = 0; m_last = 1; m_loaded = 0; m_ret = 0;
        end
        own_bit    = m_owner ? 2'b10 : 2'b01;
        loading    = m_active && (m_loaded < WI);
        unloading  = m_active && (m_loaded >= WI);
        e_eng_v    = loading && v_i[m_owner];
        e_eng_data = e_eng_v ? data_i[m_owner] : '0;
        e_ready    = (loading && eng_ready_i) ? own_bit : 2'b00;
        e_v_o      = (unloading && eng_v_i) ? own_bit : 2'b00;
        e_data_o   = (e_v_o != 0) ? eng_data_i : '0;
        e_yumi     = unloading && eng_v_i && yumi_i[m_owner];

        chk("eng_v_o", eng_v_o, e_eng_v);
        chk("eng_data_o", eng_data_o, e_eng_data);
        chk("ready_o", ready_o, e_ready);
        chk("v_o", v_o, e_v_o);
        chk("data_o", data_o, e_data_o);
        chk("eng_yumi_o", eng_yumi_o, e_yumi);
        chk("busy_o", busy_o, m_active);
        chk("owner_o", owner_o, m_owner);

        if (rst_n) begin
            if (eng_v_o && eng_ready_i) in_log.push_back(eng_data_o);
            if (eng_yumi_o) res_log.push_back(data_o);
            if (busy_o && !prev_busy) grant_log.push_back(int'(owner_o));
            if (!m_active) begin
                if (en_i && v_i != 2'b00) begin
                    m_active = 1;
                    m_owner  = (v_i == 2'b11) ? !m_last : v_i[1];
                    m_loaded = 0;
                    m_ret    = 0;
                end
            end else if (loading) begin
                if (e_eng_v && eng_ready_i) m_loaded++;
            end else if (e_yumi) begin
                m_ret++;
                if (m_ret == WO) begin
                    m_active = 0;
                    m_last   = m_owner;
                end
            end
        end
        prev_busy = busy_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        v_i = 2'b00; eng_v_i = 1'b0; yumi_i = 2'b00; eng_ready_i = 1'b1; en_i = 1'b1;
    endtask

    task automatic do_reset();
        step(); rst_n = 1'b0; idle_inputs();
        step(); rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        in_log.delete(); res_log.delete(); grant_log.delete();
    endtask

    // Drives one job for requester 'own'; returns right after the last wanted consume is set up.
    task automatic do_job(input logic [1:0] vreq, input int own, input logic [DW-1:0] base,
                          input bit bp, input int ydly, input bit early, input bit en_drop,
                          input int stop_out);
        int in_idx = 0, out_idx = 0, wc = 0, cyc = 0;
        logic [1:0] ob;
        ob = (own != 0) ? 2'b10 : 2'b01;
        while (out_idx < stop_out && cyc < 60) begin
            step(); cyc++;
            v_i         = (in_idx < WI) ? vreq : (vreq & ~ob);
            data_i[0]   = base + DW'(in_idx);
            data_i[1]   = base + 16'h0100 + DW'(in_idx);
            eng_ready_i = bp ? cyc[0] : 1'b1;
            eng_v_i     = early || (in_idx == WI);
            eng_data_i  = base + 16'h0080 + DW'(out_idx);
            yumi_i      = ~ob | ((wc >= ydly) ? ob : 2'b00);
            if (en_drop && in_idx >= 1) en_i = 1'b0;
            #2;
            if (eng_v_o && eng_ready_i) in_idx++;
            if (eng_yumi_o) begin
                out_idx++;
                wc = 0;
            end else if (v_o != 2'b00) begin
                wc++;
            end
        end
        chk("job_words_out", out_idx, stop_out);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_owner", owner_o, 0);
        chk("rst_ready", ready_o, 0);
        chk("rst_eng_v", eng_v_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single requester
        step(); v_i = 2'b01; data_i[0] = 16'hA; #2;
        chk("s_grant_ready", ready_o, 2'b00);
        chk("s_grant_busy", busy_o, 0);
        step(); data_i[0] = 16'hA; #2;
        chk("s_c2_ready", ready_o, 2'b01);
        chk("s_c2_data", eng_data_o, 16'hA);
        step(); data_i[0] = 16'hB; #2;
        chk("s_c3_data", eng_data_o, 16'hB);
        step(); data_i[0] = 16'hC; #2;
        chk("s_c4_data", eng_data_o, 16'hC);
        step(); v_i = 2'b00; eng_v_i = 1'b1; eng_data_i = 16'h1; yumi_i = 2'b01; #2;
        chk("s_r1_v", v_o, 2'b01);
        chk("s_r1_data", data_o, 16'h1);
        step(); eng_data_i = 16'h2; #2;
        chk("s_r2_data", data_o, 16'h2);
        chk("s_r2_busy", busy_o, 1);
        step(); eng_v_i = 1'b0; yumi_i = 2'b00; #2;
        chk("s_done_busy", busy_o, 0);
        chk("s_done_owner", owner_o, 0);

        // Contention: three back-to-back jobs
        do_reset(); clear_logs();
        do_job(2'b11, 0, 16'h1000, 0, 0, 0, 0, WO);
        do_job(2'b11, 1, 16'h2000, 0, 0, 0, 0, WO);
        do_job(2'b11, 0, 16'h3000, 0, 0, 0, 0, WO);
        step(); idle_inputs(); step();
        chk("c_grants", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            chk("c_g0", grant_log[0], 0);
            chk("c_g1", grant_log[1], 1);
            chk("c_g2", grant_log[2], 0);
        end
        chk("c_in_words", in_log.size(), 9);
        if (in_log.size() == 9) chk("c_in4", in_log[4], 16'h2101);

        // Backpressure
        clear_logs();
        do_job(2'b01, 0, 16'h4000, 1, 3, 0, 0, WO);
        step(); idle_inputs(); #1;
        chk("b_in_cnt", in_log.size(), 3);
        chk("b_res_cnt", res_log.size(), 2);
        if (in_log.size() == 3) begin
            chk("b_in0", in_log[0], 16'h4000);
            chk("b_in1", in_log[1], 16'h4001);
            chk("b_in2", in_log[2], 16'h4002);
        end
        if (res_log.size() == 2) begin
            chk("b_res0", res_log[0], 16'h4080);
            chk("b_res1", res_log[1], 16'h4081);
        end
        chk("b_cnt", dut.cnt, 0);
        chk("b_busy", busy_o, 0);

        // Early engine result
        clear_logs();
        do_job(2'b10, 1, 16'h5000, 0, 0, 1, 0, WO);
        step(); idle_inputs();
        chk("e_res_cnt", res_log.size(), 2);
        if (res_log.size() == 2) chk("e_res0", res_log[0], 16'h5080);

        // en_i gating
        clear_logs();
        en_i = 1'b0; v_i = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step(); #2;
            chk("g_idle_busy", busy_o, 0);
        end
        en_i = 1'b1;
        do_job(2'b10, 1, 16'h6000, 0, 0, 0, 1, WO);
        step(); idle_inputs(); #1;
        chk("g_in_cnt", in_log.size(), 3);
        chk("g_res_cnt", res_log.size(), 2);
        chk("g_busy", busy_o, 0);

        // Reset mid-UNLOAD
        do_job(2'b10, 1, 16'h7000, 0, 0, 0, 0, 1);
        step(); v_i = 2'b00; eng_v_i = 1'b1; eng_data_i = 16'h7081; yumi_i = 2'b00; #1;
        chk("r_pre_v", v_o, 2'b10);
        chk("r_pre_owner", owner_o, 1);
        rst_n = 1'b0; #1;
        chk("r_async_v", v_o, 0);
        chk("r_async_data", data_o, 0);
        chk("r_async_busy", busy_o, 0);
        chk("r_async_owner", owner_o, 0);
        chk("r_async_yumi", eng_yumi_o, 0);
        step(); idle_inputs(); rst_n = 1'b1; v_i = 2'b11;
        step(); #1;
        chk("r_regrant_busy", busy_o, 1);
        chk("r_regrant_owner", owner_o, 0);
        do_reset();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bsg_cgol_job_arbiter.md
# bsg_cgol_job_arbiter

Round-robin job arbiter that shares one `bsg_cgol` engine between two ring requesters on a test node. A job is a fixed-length burst of input words from one requester (game length plus board rows), followed by a fixed-length burst of result words from the engine. Once a requester is granted, the arbiter locks the engine to it until the last result word has been returned to that requester. The arbiter sits between the node's ring-side ports and the engine's valid/ready input and valid/yumi output.

## Interface
- `data_width_p`, 64, word width on every data port.
- `words_in_p`, 101, input words per job: 1 length word plus 100 rows of 64 bits (80x80 board). Must be ≥1.
- `words_out_p`, 100, result words per job. Must be ≥1.

- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  allows new grants; does not affect a job in flight.
- `v_i`  in  2  per-requester input valid.
- `data_i`  in  2×`data_width_p`  per-requester input word.
- `ready_o`  out  2  per-requester input ready.
- `v_o`  out  2  per-requester result valid.
- `data_o`  out  `data_width_p`  result word, shared by both requesters.
- `yumi_i`  in  2  per-requester result consume.
- `eng_v_o`  out  1  engine input valid.
- `eng_data_o`  out  `data_width_p`  engine input word.
- `eng_ready_i`  in  1  engine input ready.
- `eng_v_i`  in  1  engine result valid.
- `eng_data_i`  in  `data_width_p`  engine result word.
- `eng_yumi_o`  out  1  engine result consume.
- `busy_o`  out  1  high in LOAD or UNLOAD.
- `owner_o`  out  1  currently or most recently granted requester.

## Operation
- Registered state: `state`, `owner`, `last_grant`, and `cnt` (width `$clog2(max(words_in_p,words_out_p)+1)`).
- States: IDLE, LOAD, UNLOAD.

**IDLE**
- Every handshake output is 0.
- If `en_i`=1 and any `v_i` bit is set:
  - If exactly one bit is set, grant that requester.
  - If both are set, grant `~last_grant`.
- On a grant: `owner`←grantee, `cnt`←0, go to LOAD.
- No word transfers in the grant cycle.

**LOAD**
- `eng_v_o`=`v_i[owner]`, `eng_data_o`=`data_i[owner]`, `ready_o[owner]`=`eng_ready_i`.
- The other requester's `ready_o` is 0.
- A transfer occurs when `eng_v_o` and `eng_ready_i` are both high; `cnt` increments on each transfer.
- On the transfer with `cnt`=`words_in_p`-1: `cnt`←0, go to UNLOAD.
- In LOAD, `eng_yumi_o`=0 even if `eng_v_i`=1; an early engine result is held and not lost.

**UNLOAD**
- `v_o[owner]`=`eng_v_i`, `data_o`=`eng_data_i`, `eng_yumi_o`=`eng_v_i & yumi_i[owner]`.
- `yumi_i` from the non-owner is ignored.
- `cnt` increments on each `eng_yumi_o`.
- On the consume with `cnt`=`words_out_p`-1: `last_grant`←`owner`, go to IDLE.

**Other rules**
- `eng_data_o` is 0 whenever `eng_v_o`=0. `data_o` is 0 whenever both `v_o` bits are 0.
- `en_i` low in LOAD or UNLOAD has no effect; the job completes.
- Unused `eng_data_o`/`data_i` bits pass through unchanged (full-width copy).

## Timing
- Reset value of every output is 0. Registers reset to: state=IDLE, `owner`=0, `last_grant`=1, `cnt`=0. With this reset, requester 0 wins the first contended grant.
- Asserting reset mid-job aborts immediately to the reset values. The engine is reset by the same source at top level.
- Grant latency: 1 cycle from `v_i` high in IDLE to `ready_o[owner]` high, provided `eng_ready_i` is high.
- LOAD and UNLOAD paths are purely combinational (zero added latency). At full throughput, one word moves per cycle.
- Return to IDLE occurs the cycle after the last consume. A new grant can happen in that IDLE cycle, so the minimum gap between jobs is 1 idle cycle.
- No combinational path from `eng_ready_i` to `eng_v_o`. No combinational path from `yumi_i` to `v_o`.

## Test plan
Bench parameters: `words_in_p`=3, `words_out_p`=2.

- **Single requester:** after reset, `v_i`=01 with data 0xA, 0xB, 0xC; engine always ready and returns 0x1, 0x2.
  - `eng_data_o` sequence is A, B, C, starting on cycle 2.
  - `v_o`=01 with `data_o` 1, then 2.
  - `busy_o` falls after the second `yumi_i[0]`; `owner_o`=0.
- **Contention:** `v_i`=11 held for 3 back-to-back jobs. Grants go 0, 1, 0. Non-owner `ready_o` stays 0 throughout every job.
- **Backpressure:** `eng_ready_i` toggles 1,0,1,0; `yumi_i` is delayed 3 cycles per word.
  - Exactly 3 input words and 2 result words move.
  - No duplicate or dropped word.
  - `cnt` ends at 0.
- **Early engine result:** `eng_v_i`=1 during LOAD. `eng_yumi_o` stays 0 until UNLOAD, then the same word is delivered.
- **en_i gating:** with `en_i`=0 and `v_i`=10, the arbiter stays IDLE. Dropping `en_i` mid-LOAD still completes the job.
- **Reset mid-UNLOAD:** assert `reset_n_i`=0 after 1 result word.
  - All outputs read 0 asynchronously (before the next clock edge).
  - The next contended grant goes to requester 0.
